// File: rtl/zports_regs.sv
// ZX-bus ports register file: CONFIG/MASK/STATUS, chip reset generation and
// Z80 interrupt request. Write strobes arrive asynchronously and are
// synchronized into fclk before being accepted.
module zports_regs #(
  parameter int unsigned RST_CYCLES = 16,
  parameter logic [7:0]  CFG_RESET  = 8'h00
) (
  input  logic       fclk,
  input  logic       zrst_n,
  input  logic       ports_wrena,
  input  logic       ports_wrstb_n,
  input  logic [1:0] ports_addr,
  input  logic [7:0] ports_wrdata,
  output logic [7:0] ports_rddata,
  output logic [1:0] rommap_win,
  output logic       rommap_ena,
  output logic       w5300_ports,
  output logic       w5300_rst_n,
  output logic       sl811_rst_n,
  input  logic       w5300_int_n,
  input  logic       sl811_intrq,
  output logic       zint_n
);

  localparam logic [7:0] PorInit = 8'(RST_CYCLES);

  localparam logic [1:0] AddrSl811  = 2'd0;
  localparam logic [1:0] AddrConfig = 2'd1;
  localparam logic [1:0] AddrMask   = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  // Strobe synchronizer (s0, s1) and history (s2, s3); idle level is high.
  logic stb_s0_q, stb_s1_q, stb_s2_q, stb_s3_q;
  // Interrupt synchronizers plus one previous sample for edge detection.
  logic wint_s0_q, wint_s1_q, wint_prev_q;
  logic sint_s0_q, sint_s1_q, sint_prev_q;

  logic [5:0] cfg_q, cfg_d;
  logic [1:0] mask_q, mask_d;
  logic [1:0] pend_q, pend_d;
  logic [7:0] por_ctr_q, por_ctr_d;
  logic       w5300_rst_n_q, w5300_rst_n_d;
  logic       sl811_rst_n_q, sl811_rst_n_d;
  logic       zint_n_q, zint_n_d;

  logic       wr_accept;
  logic       wr_en;
  logic       por_active;
  logic [1:0] pend_set;

  // Upper write-data bits have no storage behind them.
  logic unused_wrdata;
  assign unused_wrdata = ^ports_wrdata[7:6];

  // Synchronizer and edge-history flops, reset to the inactive input levels so
  // that levels already asserted at reset exit do not look like edges.
  always_ff @(posedge fclk or negedge zrst_n) begin
    if (!zrst_n) begin
      stb_s0_q    <= 1'b1;
      stb_s1_q    <= 1'b1;
      stb_s2_q    <= 1'b1;
      stb_s3_q    <= 1'b1;
      wint_s0_q   <= 1'b1;
      wint_s1_q   <= 1'b1;
      wint_prev_q <= 1'b1;
      sint_s0_q   <= 1'b0;
      sint_s1_q   <= 1'b0;
      sint_prev_q <= 1'b0;
    end else begin
      stb_s0_q    <= ports_wrstb_n;
      stb_s1_q    <= stb_s0_q;
      stb_s2_q    <= stb_s1_q;
      stb_s3_q    <= stb_s2_q;
      wint_s0_q   <= w5300_int_n;
      wint_s1_q   <= wint_s0_q;
      wint_prev_q <= wint_s1_q;
      sint_s0_q   <= sl811_intrq;
      sint_s1_q   <= sint_s0_q;
      sint_prev_q <= sint_s1_q;
    end
  end

  // Accept once per strobe-low period: two low samples following a high one.
  assign wr_accept = ~stb_s1_q & ~stb_s2_q & stb_s3_q;
  assign wr_en     = wr_accept & ports_wrena;

  assign pend_set[0] = wint_prev_q & ~wint_s1_q;
  assign pend_set[1] = ~sint_prev_q & sint_s1_q;

  assign por_active = (por_ctr_q != 8'd0);

  // Register next-state: writes, W1C with set priority, reset counter, outputs.
  always_comb begin
    cfg_d  = cfg_q;
    mask_d = mask_q;
    pend_d = pend_q;
    if (wr_en) begin
      unique case (ports_addr)
        AddrConfig: cfg_d  = ports_wrdata[5:0];
        AddrMask:   mask_d = ports_wrdata[1:0];
        AddrStatus: pend_d = pend_q & ~ports_wrdata[1:0];
        default:    ;
      endcase
    end
    pend_d = pend_d | pend_set;

    por_ctr_d     = por_active ? por_ctr_q - 8'd1 : por_ctr_q;
    w5300_rst_n_d = ~(por_active | cfg_q[4]);
    sl811_rst_n_d = ~(por_active | cfg_q[5]);
    zint_n_d      = ~|(pend_q & mask_q);
  end

  // Architectural state.
  always_ff @(posedge fclk or negedge zrst_n) begin
    if (!zrst_n) begin
      cfg_q         <= CFG_RESET[5:0];
      mask_q        <= 2'b00;
      pend_q        <= 2'b00;
      por_ctr_q     <= PorInit;
      w5300_rst_n_q <= 1'b0;
      sl811_rst_n_q <= 1'b0;
      zint_n_q      <= 1'b1;
    end else begin
      cfg_q         <= cfg_d;
      mask_q        <= mask_d;
      pend_q        <= pend_d;
      por_ctr_q     <= por_ctr_d;
      w5300_rst_n_q <= w5300_rst_n_d;
      sl811_rst_n_q <= sl811_rst_n_d;
      zint_n_q      <= zint_n_d;
    end
  end

  // Read mux; reads have no side effects.
  always_comb begin
    ports_rddata = 8'hFF;
    unique case (ports_addr)
      AddrSl811:  ports_rddata = 8'hFF;
      AddrConfig: ports_rddata = {2'b00, cfg_q};
      AddrMask:   ports_rddata = {6'b0, mask_q};
      AddrStatus: ports_rddata = {2'b00, sint_s1_q, ~wint_s1_q, 2'b00, pend_q};
      default:    ports_rddata = 8'hFF;
    endcase
  end

  assign rommap_win  = cfg_q[1:0];
  assign rommap_ena  = cfg_q[2];
  assign w5300_ports = cfg_q[3];
  assign w5300_rst_n = w5300_rst_n_q;
  assign sl811_rst_n = sl811_rst_n_q;
  assign zint_n      = zint_n_q;

endmodule

// File: tb/tb_zports_regs.sv
// Scoreboard bench for zports_regs: stimulus pushes expectations derived from
// a register-level model, a monitor checks them on the falling clock edge.
module tb_zports_regs;

  logic       fclk = 1'b0;
  logic       zrst_n = 1'b0;
  logic       ports_wrena = 1'b0;
  logic       ports_wrstb_n = 1'b1;
  logic [1:0] ports_addr = 2'd0;
  logic [7:0] ports_wrdata = 8'h00;
  logic [7:0] ports_rddata;
  logic [1:0] rommap_win;
  logic       rommap_ena, w5300_ports, w5300_rst_n, sl811_rst_n, zint_n;
  logic       w5300_int_n = 1'b1;
  logic       sl811_intrq = 1'b0;

  zports_regs #(.RST_CYCLES(16), .CFG_RESET(8'h00)) dut (
    .fclk(fclk), .zrst_n(zrst_n), .ports_wrena(ports_wrena),
    .ports_wrstb_n(ports_wrstb_n), .ports_addr(ports_addr),
    .ports_wrdata(ports_wrdata), .ports_rddata(ports_rddata),
    .rommap_win(rommap_win), .rommap_ena(rommap_ena), .w5300_ports(w5300_ports),
    .w5300_rst_n(w5300_rst_n), .sl811_rst_n(sl811_rst_n),
    .w5300_int_n(w5300_int_n), .sl811_intrq(sl811_intrq), .zint_n(zint_n)
  );

  always #5 fclk = ~fclk;

  typedef struct {
    int         kind;  // 0: ports_rddata, 1: output bundle
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t sb_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  // Register-level model of the programmer-visible state.
  logic [7:0] m_cfg = 8'h00;
  logic [7:0] m_mask = 8'h00;
  logic [1:0] m_pend = 2'b00;
  logic       m_wlow = 1'b0;
  logic       m_shigh = 1'b0;

  function automatic logic [7:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd1:    return m_cfg & 8'h3F;
      2'd2:    return m_mask & 8'h03;
      2'd3:    return {2'b00, m_shigh, m_wlow, 2'b00, m_pend};
      default: return 8'hFF;
    endcase
  endfunction

  // {0, zint_n, w5300_rst_n, sl811_rst_n, w5300_ports, rommap_ena, rommap_win}
  function automatic logic [7:0] exp_outs();
    logic irq;
    irq = (m_pend[0] && m_mask[0]) || (m_pend[1] && m_mask[1]);
    return {1'b0, !irq, !m_cfg[4], !m_cfg[5], m_cfg[3], m_cfg[2], m_cfg[1:0]};
  endfunction

  // Monitor: compares one queued expectation per falling edge.
  always @(negedge fclk) begin
    if (sb_q.size() != 0) begin
      chk_t c;
      logic [7:0] act;
      c = sb_q.pop_front();
      if (c.kind == 0) act = ports_rddata;
      else act = {1'b0, zint_n, w5300_rst_n, sl811_rst_n, w5300_ports, rommap_ena, rommap_win};
      n_checks = n_checks + 1;
      if (act !== c.exp) begin
        n_err = n_err + 1;
        $display("FAIL %s: got %02h expected %02h", c.name, act, c.exp);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge fclk);
    if (sb_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic push(input int kind, input logic [7:0] exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb_q.push_back(c);
    drain();
  endtask

  task automatic check_rd(input logic [1:0] a, input string name);
    ports_addr = a;
    push(0, exp_rd(a), name);
  endtask

  task automatic check_outs(input string name);
    push(1, exp_outs(), name);
  endtask

  task automatic model_write(input logic [1:0] a, input logic [7:0] d);
    case (a)
      2'd1: m_cfg = d & 8'h3F;
      2'd2: m_mask = d & 8'h03;
      2'd3: m_pend = m_pend & ~d[1:0];
      default: ;
    endcase
  endtask

  // One bus write with the strobe low for lowc sampled clock edges.
  task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic en, input int lowc);
    @(posedge fclk);
    #2;
    ports_addr = a;
    ports_wrdata = d;
    ports_wrena = en;
    ports_wrstb_n = 1'b0;
    repeat (lowc) @(posedge fclk);
    #2 ports_wrstb_n = 1'b1;
    repeat (4) @(posedge fclk);
    #1;
    ports_wrena = 1'b0;
    if (en && lowc >= 2) model_write(a, d);
  endtask

  initial begin
    // Reset state and reset-counter release.
    repeat (3) @(posedge fclk);
    #1 push(1, 8'h40, "reset_outs");
    @(negedge fclk);
    zrst_n = 1'b1;
    @(posedge fclk);
    for (int k = 1; k <= 18; k++) begin
      #1;
      if (k <= 15) push(1, exp_outs() & 8'hCF, $sformatf("por_hold_%0d", k));
      else if (k == 18) push(1, exp_outs(), "por_released");
      else drain();
      if (k == 16 || k == 17) @(posedge fclk);
    end
    check_rd(2'd1, "reset_cfg_rd");
    check_rd(2'd0, "offset0_rd");
    check_rd(2'd3, "reset_status_rd");

    // Long strobe: update within 4 cycles, exactly one write.
    @(posedge fclk);
    #2;
    ports_addr = 2'd1;
    ports_wrdata = 8'h07;
    ports_wrena = 1'b1;
    ports_wrstb_n = 1'b0;
    repeat (4) @(posedge fclk);
    #1 m_cfg = 8'h07;
    check_outs("cfg_latency");
    ports_wrdata = 8'h3C;  // a second accept in the same low period would land this
    @(posedge fclk);
    #2 ports_wrstb_n = 1'b1;
    repeat (4) @(posedge fclk);
    #1 ports_wrena = 1'b0;
    check_rd(2'd1, "cfg_single_write");
    check_outs("cfg_outs");

    // Ignored writes: one-sample strobe, wrena low.
    wr(2'd1, 8'h0F, 1'b1, 1);
    check_rd(2'd1, "short_strobe_ignored");
    wr(2'd1, 8'h0F, 1'b0, 4);
    check_rd(2'd1, "wrena_low_ignored");

    // W5300 interrupt, then W1C while the level stays low.
    wr(2'd2, 8'h01, 1'b1, 3);
    @(posedge fclk);
    #2 w5300_int_n = 1'b0;
    repeat (4) @(posedge fclk);
    #1;
    m_wlow = 1'b1;
    m_pend[0] = 1'b1;
    check_outs("w5300_irq");
    check_rd(2'd3, "w5300_pending");
    wr(2'd3, 8'h01, 1'b1, 3);
    check_rd(2'd3, "w5300_w1c");
    check_outs("w5300_w1c_zint");

    // SL811 interrupt masked, then unmasked.
    wr(2'd2, 8'h00, 1'b1, 3);
    @(posedge fclk);
    #2 sl811_intrq = 1'b1;
    repeat (4) @(posedge fclk);
    #1;
    m_shigh = 1'b1;
    m_pend[1] = 1'b1;
    check_rd(2'd3, "sl811_pending");
    check_outs("sl811_masked");
    wr(2'd2, 8'h02, 1'b1, 3);
    check_outs("sl811_unmasked");

    // W1C colliding with a new rising edge: the set wins.
    sl811_intrq = 1'b0;
    m_shigh = 1'b0;
    repeat (4) @(posedge fclk);
    #2;
    ports_addr = 2'd3;
    ports_wrdata = 8'h02;
    ports_wrena = 1'b1;
    ports_wrstb_n = 1'b0;
    @(posedge fclk);
    #2 sl811_intrq = 1'b1;
    repeat (3) @(posedge fclk);
    #2 ports_wrstb_n = 1'b1;
    repeat (4) @(posedge fclk);
    #1;
    ports_wrena = 1'b0;
    m_shigh = 1'b1;
    check_rd(2'd3, "set_beats_w1c");
    check_outs("set_beats_w1c_zint");

    // Software reset hold on the W5300.
    wr(2'd1, 8'h17, 1'b1, 2);
    check_outs("w5300_hold");
    wr(2'd1, 8'h07, 1'b1, 2);
    check_outs("w5300_release");

    // Randomized register traffic against the model.
    for (int i = 0; i < 24; i++) begin
      logic [1:0] a;
      logic [7:0] d;
      logic       en;
      int         lowc;
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      en = ($urandom_range(0, 3) != 0);
      lowc = $urandom_range(1, 5);
      wr(a, d, en, lowc);
      check_rd(2'($urandom_range(0, 3)), $sformatf("rand_rd_%0d", i));
      check_outs($sformatf("rand_outs_%0d", i));
    end

    drain();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
